// File: rtl/dac_pacer_pkg.sv
// Shared types and default sizing for the DAC sample pacer.
// Pure declarations: no logic, no latency, no flow control.
package dac_pacer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } pacer_state_t;

  localparam int DEFAULT_SW         = 16;
  localparam int DEFAULT_LW         = 12;
  localparam int DEFAULT_STARVE_LIM = 4;
  localparam int DEFAULT_CNT_W      = 16;

  // STARVE_LIM is bounded to 1..255, so eight bits always hold the run length.
  localparam int STARVE_W = 8;

endpackage

// File: rtl/sr_edge_det.sv
// Rising-edge detector for srgen sample clocks (clkout / clkoutd consumers).
// Latency: rise is combinational from sig and the one-cycle delayed copy.
// Backpressure: none; every rising edge yields exactly one single-cycle pulse.
module sr_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_d;

  // Delay register resets high so a level already high at reset release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_d <= 1'b1;
    end else begin
      sig_d <= sig;
    end
  end

  assign rise = sig & ~sig_d;

endmodule

// File: rtl/dac_sample_pacer.sv
// Paces FIFO I/Q samples onto the DAC at the srgen symbol rate; optional DAC_PACER_UFCNT_EN underflow counter.
// Latency: pop is combinational with the tick; dac_i/dac_q/dac_strobe/underflow update one cycle later.
// Backpressure: exactly one pop per tick in RUN; an empty FIFO on a tick inserts a zero sample instead of stalling.
module dac_sample_pacer
  import dac_pacer_pkg::*;
#(
  parameter int SW         = DEFAULT_SW,
  parameter int LW         = DEFAULT_LW,
  parameter int STARVE_LIM = DEFAULT_STARVE_LIM,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic            clkin,
  input  logic            rst,
  input  logic            enable,
  input  logic            sr_clk,
  input  logic            s_valid,
  input  logic [2*SW-1:0] s_data,
  output logic            s_ready,
  input  logic [LW-1:0]   fifo_level,
  input  logic [LW-1:0]   prefill,
  output logic [SW-1:0]   dac_i,
  output logic [SW-1:0]   dac_q,
  output logic            dac_strobe,
  output logic            running,
  output logic            underflow,
  output logic [CNT_W-1:0] underflow_cnt
);

  localparam logic [STARVE_W-1:0] STARVE_LIM_V = STARVE_W'(STARVE_LIM);

  pacer_state_t         state;
  pacer_state_t         state_nxt;
  logic                 tick;
  logic                 run_tick;
  logic                 starved_tick;
  logic                 starve_hit;
  logic                 start_fill;
  logic                 fill_done;
  logic [STARVE_W-1:0]  starve_cnt;

  sr_edge_det u_sr_edge (
    .clk  (clkin),
    .rst  (rst),
    .sig  (sr_clk),
    .rise (tick)
  );

  // enable is folded in so a drop on a tick cycle neither pops nor loads.
  assign run_tick     = enable & (state == ST_RUN) & tick;
  assign starved_tick = run_tick & ~s_valid;
  assign starve_hit   = starved_tick & ((starve_cnt + STARVE_W'(1)) == STARVE_LIM_V);
  assign start_fill   = enable & (state == ST_IDLE);
  assign fill_done    = (fifo_level >= prefill);

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_nxt = ST_PREFILL;
        ST_PREFILL: if (fill_done) state_nxt = ST_RUN;
        ST_RUN:     if (starve_hit) state_nxt = ST_PREFILL;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready = 1'b0;
    running = 1'b0;
    case (state)
      ST_RUN: begin
        running = 1'b1;
        s_ready = tick & enable;
      end
      default: begin
        s_ready = 1'b0;
        running = 1'b0;
      end
    endcase
  end

  // Consecutive-underflow run length; any real sample breaks the run.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (start_fill) begin
      starve_cnt <= '0;
    end else if (run_tick) begin
      if (s_valid || starve_hit) begin
        starve_cnt <= '0;
      end else begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      dac_i      <= '0;
      dac_q      <= '0;
      dac_strobe <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      dac_strobe <= run_tick;
      underflow  <= starved_tick;
      if (!enable || (state == ST_IDLE)) begin
        dac_i <= '0;
        dac_q <= '0;
      end else if (run_tick) begin
        if (s_valid) begin
          dac_i <= s_data[2*SW-1:SW];
          dac_q <= s_data[SW-1:0];
        end else begin
          dac_i <= '0;
          dac_q <= '0;
        end
      end
    end
  end

`ifdef DAC_PACER_UFCNT_EN
  logic [CNT_W-1:0] uf_cnt;

  // Saturates at all-ones so a long outage never wraps back to a small count.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      uf_cnt <= '0;
    end else if (start_fill) begin
      uf_cnt <= '0;
    end else if (starved_tick && (uf_cnt != {CNT_W{1'b1}})) begin
      uf_cnt <= uf_cnt + CNT_W'(1);
    end
  end

  assign underflow_cnt = uf_cnt;
`else
  assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Randomized scoreboard bench for dac_sample_pacer against a transaction-level model.
module tb_dac_sample_pacer;

  localparam int SW    = 16;
  localparam int LW    = 12;
  localparam int LIM   = 4;
  localparam int CNT_W = 16;

  logic             clkin = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             sr_clk = 1'b1;
  logic             s_valid = 1'b0;
  logic [2*SW-1:0]  s_data = '0;
  logic             s_ready;
  logic [LW-1:0]    fifo_level = '0;
  logic [LW-1:0]    prefill = '0;
  logic [SW-1:0]    dac_i;
  logic [SW-1:0]    dac_q;
  logic             dac_strobe;
  logic             running;
  logic             underflow;
  logic [CNT_W-1:0] underflow_cnt;

  dac_sample_pacer #(.SW(SW), .LW(LW), .STARVE_LIM(LIM), .CNT_W(CNT_W)) dut (
    .clkin         (clkin),
    .rst           (rst),
    .enable        (enable),
    .sr_clk        (sr_clk),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .fifo_level    (fifo_level),
    .prefill       (prefill),
    .dac_i         (dac_i),
    .dac_q         (dac_q),
    .dac_strobe    (dac_strobe),
    .running       (running),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  always #5 clkin = ~clkin;

  typedef struct { bit rdy; bit run; bit idle; } cyc_t;
  typedef struct { logic [SW-1:0] i; logic [SW-1:0] q; bit uf; logic [CNT_W-1:0] ucnt; } smp_t;

  cyc_t cyc_q[$];
  smp_t smp_q[$];
  cyc_t mc;
  smp_t ms;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;
  int uf_seen = 0;

  // Model: 0 = stopped, 1 = waiting for fill, 2 = playing.
  int m_mode;
  bit m_sr_prev;
  int m_starve;
  int m_ufcnt;
  bit pop_pend;
  int sr_per = 10;
  int sr_ph = 0;
  bit sr_hold = 1'b1;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_sr_prev = 1'b1;
    m_starve = 0;
    m_ufcnt = 0;
    pop_pend = 1'b0;
  endtask

  function automatic logic [CNT_W-1:0] ucnt_exp();
`ifdef DAC_PACER_UFCNT_EN
    return CNT_W'(m_ufcnt);
`else
    return '0;
`endif
  endfunction

  task automatic model_step();
    bit   tk;
    int   nxt;
    cyc_t c;
    smp_t s;
    tk = sr_clk && !m_sr_prev;
    m_sr_prev = sr_clk;
    c.rdy  = enable && (m_mode == 2) && tk;
    c.run  = (m_mode == 2);
    c.idle = (m_mode == 0);
    cyc_q.push_back(c);
    nxt = m_mode;
    if (c.rdy) begin
      if (s_valid) begin
        s.i = s_data[2*SW-1:SW];
        s.q = s_data[SW-1:0];
        s.uf = 1'b0;
        m_starve = 0;
      end else begin
        s.i = '0;
        s.q = '0;
        s.uf = 1'b1;
        m_starve++;
        if (m_ufcnt < (1 << CNT_W) - 1) m_ufcnt++;
        if (m_starve == LIM) begin
          m_starve = 0;
          nxt = 1;
        end
      end
      s.ucnt = ucnt_exp();
      smp_q.push_back(s);
    end
    pop_pend = c.rdy;
    if (!enable) begin
      nxt = 0;
    end else if (m_mode == 0) begin
      nxt = 1;
      m_starve = 0;
      m_ufcnt = 0;
    end else if (m_mode == 1 && fifo_level >= prefill) begin
      nxt = 2;
    end
    m_mode = nxt;
  endtask

  task automatic cycle();
    if (pop_pend) s_data = $urandom;
    if (sr_hold) begin
      sr_clk = 1'b1;
    end else begin
      sr_clk = (sr_ph < sr_per / 2);
      sr_ph = (sr_ph + 1) % sr_per;
    end
    model_step();
    @(posedge clkin);
    #1;
  endtask

  function automatic bit would_tick();
    return !sr_hold && (sr_ph < sr_per / 2) && !m_sr_prev && (m_mode == 2);
  endfunction

  task automatic run_to_tick(input string name);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (would_tick()) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    chk(found, name, found, 1);
  endtask

  always @(negedge clkin) begin
    if (mon_on) begin
      if (cyc_q.size() == 0) begin
        chk(1'b0, "cycle_queue_empty", 0, 1);
      end else begin
        mc = cyc_q.pop_front();
        chk(s_ready === mc.rdy, "s_ready", s_ready, mc.rdy);
        chk(running === mc.run, "running", running, mc.run);
        if (mc.idle) begin
          chk(dac_i === '0, "idle_dac_i", dac_i, 0);
          chk(dac_q === '0, "idle_dac_q", dac_q, 0);
        end
      end
      if (dac_strobe === 1'b1) begin
        if (smp_q.size() == 0) begin
          chk(1'b0, "unexpected_strobe", 1, 0);
        end else begin
          ms = smp_q.pop_front();
          chk(dac_i === ms.i, "dac_i", dac_i, ms.i);
          chk(dac_q === ms.q, "dac_q", dac_q, ms.q);
          chk(underflow === ms.uf, "underflow", underflow, ms.uf);
          chk(underflow_cnt === ms.ucnt, "underflow_cnt", underflow_cnt, ms.ucnt);
        end
      end else begin
        chk(underflow === 1'b0, "underflow_without_strobe", underflow, 0);
      end
      if (underflow === 1'b1) uf_seen++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int uf0;
    model_reset();
    repeat (3) @(posedge clkin);
    #1;
    chk(s_ready === 1'b0, "reset_s_ready", s_ready, 0);
    chk(dac_i === '0, "reset_dac_i", dac_i, 0);
    chk(dac_q === '0, "reset_dac_q", dac_q, 0);
    chk(dac_strobe === 1'b0, "reset_dac_strobe", dac_strobe, 0);
    chk(running === 1'b0, "reset_running", running, 0);
    chk(underflow === 1'b0, "reset_underflow", underflow, 0);
    chk(underflow_cnt === '0, "reset_underflow_cnt", underflow_cnt, 0);

    // sr_clk held high across reset release and into RUN: no tick may appear.
    rst = 1'b0;
    mon_on = 1'b1;
    repeat (2) cycle();
    prefill = '0;
    enable = 1'b1;
    repeat (6) cycle();

    // Prefill ramp to 8, then streaming at a 10-cycle sample clock.
    enable = 1'b0;
    cycle();
    sr_hold = 1'b0;
    sr_per = 10;
    sr_ph = 0;
    prefill = 12'd8;
    s_valid = 1'b1;
    s_data = $urandom;
    enable = 1'b1;
    for (int lvl = 0; lvl <= 8; lvl++) begin
      fifo_level = LW'(lvl);
      cycle();
    end
    cycle();
    chk(running === 1'b1, "prefill_running", running, 1);
    repeat (200) cycle();

    // One starved tick: zero sample, one pulse, stays in RUN.
    run_to_tick("single_uf_tick_wait");
    s_valid = 1'b0;
    cycle();
    s_valid = 1'b1;
    repeat (3) cycle();
    chk(running === 1'b1, "single_uf_stays_run", running, 1);
    repeat (20) cycle();

    // Sustained starvation falls back to PREFILL after LIM ticks.
    uf0 = uf_seen;
    fifo_level = '0;
    s_valid = 1'b0;
    run_to_tick("starve_tick_wait");
    repeat (LIM * 10 + 4) cycle();
    chk(uf_seen - uf0 == LIM, "starve_pulses", uf_seen - uf0, LIM);
    chk(running === 1'b0, "starve_left_run", running, 0);

    // Enable drop exactly on a tick.
    s_valid = 1'b1;
    fifo_level = 12'd20;
    repeat (5) cycle();
    run_to_tick("en_drop_tick_wait");
    enable = 1'b0;
    cycle();
    cycle();
    chk(running === 1'b0, "en_drop_running", running, 0);
    chk(dac_i === '0, "en_drop_dac_i", dac_i, 0);

    // Asynchronous reset in the middle of RUN.
    enable = 1'b1;
    repeat (40) cycle();
    mon_on = 1'b0;
    rst = 1'b1;
    #1;
    chk(s_ready === 1'b0, "arst_s_ready", s_ready, 0);
    chk(running === 1'b0, "arst_running", running, 0);
    chk(dac_strobe === 1'b0, "arst_dac_strobe", dac_strobe, 0);
    cyc_q.delete();
    smp_q.delete();
    sr_hold = 1'b1;
    sr_clk = 1'b1;
    repeat (2) @(posedge clkin);
    #1;
    model_reset();
    rst = 1'b0;
    mon_on = 1'b1;
    repeat (8) cycle();
    sr_hold = 1'b0;
    sr_ph = 0;

    // Randomized soak: varying rate, prefill, level, validity and rare enable drops.
    for (int n = 0; n < 3000; n++) begin
      if (n % 50 == 0) begin
        sr_per = $urandom_range(2, 12);
        sr_ph = 0;
        prefill = LW'($urandom_range(0, 6));
      end
      fifo_level = LW'($urandom_range(0, 10));
      s_valid = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 99) != 0);
      cycle();
    end

    enable = 1'b0;
    repeat (5) cycle();
    chk(smp_q.size() == 0, "pending_samples", smp_q.size(), 0);
    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
